man_result_mux: RTL
===================

MAN_RESULT_MUX -- requirements
Module: man_result_mux

Interface
REQ-001 Parameter NE, default 4: number of Mandelbrot engines merged; legal range 1..16.
REQ-002 Parameter AW, default 19: pixel address width.
REQ-003 Parameter DW, default 8: iteration-count (data) width.
REQ-004 Parameter NPIX, default 480000: pixels per frame; PCW = $clog2(NPIX+1); SW = max(1, $clog2(NE)).
REQ-005 clk  input  1  clock; the single clock of the block.
REQ-006 clk_en  input  1  clock enable; all state advances only when high.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 init  input  1  frame start pulse; clears frame counter and done.
REQ-009 in_vld  input  NE  per-engine result valid.
REQ-010 in_rdy  output  NE  per-engine result accepted.
REQ-011 in_dat  input  NE*DW  per-engine iteration count; channel i occupies bits [i*DW +: DW].
REQ-012 in_adr  input  NE*AW  per-engine pixel address; channel i occupies bits [i*AW +: AW].
REQ-013 out_vld  output  1  merged result valid.
REQ-014 out_rdy  input  1  downstream (video FIFO) ready.
REQ-015 out_dat  output  DW  merged iteration count.
REQ-016 out_adr  output  AW  merged pixel address.
REQ-017 out_src  output  SW  index of the engine that produced the current output.
REQ-018 pix_cnt  output  PCW  results delivered downstream this frame.
REQ-019 done  output  1  frame complete.
REQ-020 stall_cnt  output  16  output back-pressure cycle count.

Function
REQ-021 Transfer rules: input transfer on channel i = clk_en & in_vld[i] & in_rdy[i]; output transfer = clk_en & out_vld & out_rdy.
REQ-022 Output stage is one register; load_ok = !out_vld | out_rdy.
REQ-023 Arbiter is round-robin: grant goes to the first channel with in_vld set, searching from ptr upward and wrapping NE-1 -> 0.
REQ-024 in_rdy[i] is high only for the granted channel, and only when load_ok and clk_en are both high; at most one bit of in_rdy is set in any cycle.
REQ-025 On an input transfer from channel g: out_dat, out_adr and out_src load channel g's data, out_vld is set next cycle, and ptr becomes (g+1) mod NE.
REQ-026 With no input transfer, an output transfer clears out_vld; otherwise out_* holds stable.
REQ-027 Latency is 1 cycle from input transfer to out_vld; sustained throughput is 1 result per cycle with out_rdy held high.
REQ-028 pix_cnt increments by 1 on each output transfer and saturates at NPIX.
REQ-029 done sets on the cycle after the output transfer that brings pix_cnt to NPIX; it stays high until init or rst.
REQ-030 init (sampled when clk_en is high) sets pix_cnt and done to 0 next cycle.
REQ-031 init takes priority over a simultaneous output transfer: that transfer completes downstream but is not counted.
REQ-032 init does not flush the output register or reset ptr.
REQ-033 While clk_en is low, all registers hold and in_rdy is 0.
REQ-034 For NE=1 the block is a 1-deep register slice; out_src is constantly 0.

Reset
REQ-035 On rst (synchronous, active-high; overrides clk_en and init), the following are cleared: out_vld=0, out_dat=0, out_adr=0, out_src=0, ptr=0, pix_cnt=0, done=0, stall_cnt=0.
REQ-036 Reset mid-frame discards any held output result without an output transfer.

Configuration
REQ-037 Macro MAN_RESULT_MUX_STATS_EN defined: stall_cnt increments on each cycle where clk_en & out_vld & !out_rdy, saturates at 16'hFFFF, and is cleared by rst or init.
REQ-038 Macro MAN_RESULT_MUX_STATS_EN undefined: stall_cnt is constant 0 and no counter logic is built.

Verification
REQ-039 Reset scenario: rst high 2 cycles with all in_vld=4'hF -> out_vld=0, in_rdy=0, pix_cnt=0, done=0, stall_cnt=0.
REQ-040 Arbitration scenario: NE=4, in_vld=4'hF constant, out_rdy=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles; out_adr/out_dat match the selected channel.
REQ-041 Back-pressure scenario: out_vld=1, out_src=2, out_rdy=0 for 3 cycles -> out_adr/out_dat stable, in_rdy=0; with MAN_RESULT_MUX_STATS_EN, stall_cnt=3.
REQ-042 Frame completion scenario: NPIX=8, 8 output transfers -> pix_cnt=8, done=1 one cycle after the 8th transfer; a 9th transfer leaves pix_cnt at 8; init -> pix_cnt=0, done=0.
REQ-043 init-collision scenario: init coincides with an output transfer at pix_cnt=5 -> next cycle pix_cnt=0; the transferred result is still presented downstream.
REQ-044 Clock-enable and sparse-valid scenario: clk_en=0 for 4 cycles mid-stream -> no state change, in_rdy=0; then in_vld=4'b1010 with ptr=0 -> channel 1 granted, then channel 3.

Source files
------------

// File: rtl/man_result_mux.sv
// Round-robin merge of NE engine results into one registered output with frame pixel count.
// Latency 1 cycle in->out; a stalled output (out_rdy low) drops all in_rdy. Optional macro: MAN_RESULT_MUX_STATS_EN.
module man_result_mux #(
  parameter int NE   = 4,
  parameter int AW   = 19,
  parameter int DW   = 8,
  parameter int NPIX = 480000,
  localparam int PCW = $clog2(NPIX + 1),
  localparam int SW  = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic             rst,
  input  logic             init,
  input  logic [NE-1:0]    in_vld,
  output logic [NE-1:0]    in_rdy,
  input  logic [NE*DW-1:0] in_dat,
  input  logic [NE*AW-1:0] in_adr,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    out_dat,
  output logic [AW-1:0]    out_adr,
  output logic [SW-1:0]    out_src,
  output logic [PCW-1:0]   pix_cnt,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam logic [PCW-1:0] NPIX_C = PCW'(NPIX);

  logic           out_vld_q, out_vld_d;
  logic [DW-1:0]  out_dat_q, out_dat_d;
  logic [AW-1:0]  out_adr_q, out_adr_d;
  logic [SW-1:0]  out_src_q, out_src_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic           done_q, done_d;

  logic           gnt_found;
  logic [SW-1:0]  gnt_idx;
  logic           load_ok, in_xfer, out_xfer;

  // First valid channel at or above ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NE; k++) begin
      if (!gnt_found && in_vld[(int'(ptr_q) + k) % NE]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'((int'(ptr_q) + k) % NE);
      end
    end
  end

  assign load_ok  = !out_vld_q || out_rdy;
  assign in_xfer  = clk_en && !rst && load_ok && gnt_found;
  assign out_xfer = clk_en && out_vld_q && out_rdy;

  always_comb begin
    in_rdy = '0;
    if (in_xfer) in_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_adr_d = out_adr_q;
    out_src_d = out_src_q;
    ptr_d     = ptr_q;
    pix_cnt_d = pix_cnt_q;
    done_d    = done_q;
    if (in_xfer) begin
      out_vld_d = 1'b1;
      out_dat_d = in_dat[int'(gnt_idx)*DW +: DW];
      out_adr_d = in_adr[int'(gnt_idx)*AW +: AW];
      out_src_d = gnt_idx;
      ptr_d     = (gnt_idx == SW'(NE - 1)) ? '0 : gnt_idx + SW'(1);
    end else if (out_xfer) begin
      out_vld_d = 1'b0;
    end
    // init wins over a coincident output transfer: that result leaves uncounted.
    if (clk_en) begin
      if (init) begin
        pix_cnt_d = '0;
        done_d    = 1'b0;
      end else if (out_xfer && pix_cnt_q != NPIX_C) begin
        pix_cnt_d = pix_cnt_q + PCW'(1);
        if (pix_cnt_q == NPIX_C - PCW'(1)) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_adr_q <= '0;
      out_src_q <= '0;
      ptr_q     <= '0;
      pix_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_adr_q <= out_adr_d;
      out_src_q <= out_src_d;
      ptr_q     <= ptr_d;
      pix_cnt_q <= pix_cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef MAN_RESULT_MUX_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clk_en) begin
      if (init) stall_cnt_d = '0;
      else if (out_vld_q && !out_rdy && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_adr = out_adr_q;
  assign out_src = out_src_q;
  assign pix_cnt = pix_cnt_q;
  assign done    = done_q;

endmodule
